// File: rtl/mult_2_partial_if.sv
// Bus between mult stage 1, mult stage 2 and mult stage 3, plus stall/flush/busy to and from hazard control.
// The master modport is the upstream/hazard side. The slave modport is the stage-2 datapath.
interface mult_2_partial_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned REG_W = 5
);
   logic                 m1_m2_oper;
   logic [WIDTH-1:0]     m1_m2_mag_a;
   logic [WIDTH-1:0]     m1_m2_mag_b;
   logic [REG_W-1:0]     m1_m2_regdest;
   logic                 m1_m2_ispositive;
   logic                 m1_m2_iszero;
   logic                 m2_stall;
   logic                 m2_flush;
   logic                 m2_m3_oper;
   logic [2*WIDTH-1:0]   m2_m3_multres;
   logic [REG_W-1:0]     m2_m3_regdest;
   logic                 m2_m3_ispositive;
   logic                 m2_m3_iszero;
   logic                 m2_busy;

   modport master (
      output m1_m2_oper, m1_m2_mag_a, m1_m2_mag_b, m1_m2_regdest,
             m1_m2_ispositive, m1_m2_iszero, m2_stall, m2_flush,
      input  m2_m3_oper, m2_m3_multres, m2_m3_regdest,
             m2_m3_ispositive, m2_m3_iszero, m2_busy
   );

   modport slave (
      input  m1_m2_oper, m1_m2_mag_a, m1_m2_mag_b, m1_m2_regdest,
             m1_m2_ispositive, m1_m2_iszero, m2_stall, m2_flush,
      output m2_m3_oper, m2_m3_multres, m2_m3_regdest,
             m2_m3_ispositive, m2_m3_iszero, m2_busy
   );
endinterface

// File: rtl/mult_2_partial.sv
// Multiplier pipeline stage 2. It forms four half-width partial products in sub-stage A.
// Sub-stage B sums them into the exact unsigned 2*WIDTH product. Stall and flush apply to both sub-stages.
module mult_2_partial #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned REG_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   mult_2_partial_if.slave   bus
);
   localparam int unsigned HALF = WIDTH / 2;

   // Half-words zero-extended to WIDTH, so each product is computed at full WIDTH.
   logic [WIDTH-1:0] a_lo, a_hi, b_lo, b_hi;
   assign a_lo = {{(WIDTH-HALF){1'b0}}, bus.m1_m2_mag_a[HALF-1:0]};
   assign a_hi = {{(WIDTH-HALF){1'b0}}, bus.m1_m2_mag_a[WIDTH-1:HALF]};
   assign b_lo = {{(WIDTH-HALF){1'b0}}, bus.m1_m2_mag_b[HALF-1:0]};
   assign b_hi = {{(WIDTH-HALF){1'b0}}, bus.m1_m2_mag_b[WIDTH-1:HALF]};

   logic               valid_a;
   logic [WIDTH-1:0]   pp_ll, pp_lh, pp_hl, pp_hh;
   logic [REG_W-1:0]   regdest_a;
   logic               ispositive_a;
   logic               iszero_a;

   logic               oper_b;
   logic [2*WIDTH-1:0] multres_b;
   logic [REG_W-1:0]   regdest_b;
   logic               ispositive_b;
   logic               iszero_b;

   logic [2*WIDTH-1:0] sum_b;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_a      <= 1'b0;
         pp_ll        <= '0;
         pp_lh        <= '0;
         pp_hl        <= '0;
         pp_hh        <= '0;
         regdest_a    <= '0;
         ispositive_a <= 1'b0;
         iszero_a     <= 1'b0;
      end else if (bus.m2_flush || (!bus.m2_stall && !bus.m1_m2_oper)) begin
         valid_a      <= 1'b0;
         pp_ll        <= '0;
         pp_lh        <= '0;
         pp_hl        <= '0;
         pp_hh        <= '0;
         regdest_a    <= '0;
         ispositive_a <= 1'b0;
         iszero_a     <= 1'b0;
      end else if (!bus.m2_stall) begin
         valid_a      <= 1'b1;
         pp_ll        <= a_lo * b_lo;
         pp_lh        <= a_lo * b_hi;
         pp_hl        <= a_hi * b_lo;
         pp_hh        <= a_hi * b_hi;
         regdest_a    <= bus.m1_m2_regdest;
         ispositive_a <= bus.m1_m2_ispositive;
         iszero_a     <= bus.m1_m2_iszero;
      end
   end

   always_comb begin
      sum_b = {{WIDTH{1'b0}}, pp_ll}
            + ({{WIDTH{1'b0}}, pp_lh} << HALF)
            + ({{WIDTH{1'b0}}, pp_hl} << HALF)
            + {pp_hh, {WIDTH{1'b0}}};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         oper_b       <= 1'b0;
         multres_b    <= '0;
         regdest_b    <= '0;
         ispositive_b <= 1'b0;
         iszero_b     <= 1'b0;
      end else if (bus.m2_flush) begin
         oper_b       <= 1'b0;
         multres_b    <= '0;
         regdest_b    <= '0;
         ispositive_b <= 1'b0;
         iszero_b     <= 1'b0;
      end else if (!bus.m2_stall) begin
         oper_b       <= valid_a;
         multres_b    <= iszero_a ? '0 : sum_b;
         regdest_b    <= regdest_a;
         ispositive_b <= ispositive_a;
         iszero_b     <= iszero_a;
      end
   end

   assign bus.m2_m3_oper       = oper_b;
   assign bus.m2_m3_multres    = multres_b;
   assign bus.m2_m3_regdest    = regdest_b;
   assign bus.m2_m3_ispositive = ispositive_b;
   assign bus.m2_m3_iszero     = iszero_b;
   assign bus.m2_busy          = valid_a | oper_b;
endmodule

// File: tb/tb_mult_2_partial.sv
// Directed bench for mult_2_partial. Inputs change 1ns after each rising edge, and outputs are checked at the same point.
`timescale 1ns/1ps
module tb_mult_2_partial;
   logic clock;
   logic reset;
   int   tests;
   int   failed;

   mult_2_partial_if #(.WIDTH(32), .REG_W(5)) bus ();

   mult_2_partial #(.WIDTH(32), .REG_W(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic oper, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic pos, input logic zero);
      bus.m1_m2_oper       = oper;
      bus.m1_m2_mag_a      = a;
      bus.m1_m2_mag_b      = b;
      bus.m1_m2_regdest    = rd;
      bus.m1_m2_ispositive = pos;
      bus.m1_m2_iszero     = zero;
   endtask

   task automatic idle();
      drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset        = 1'b0;
      bus.m2_stall = 1'b0;
      bus.m2_flush = 1'b0;
      drive(1'b1, 32'd3, 32'd3, 5'd3, 1'b1, 1'b0);
      cyc();
      cyc();
      tests++;
      if (bus.m2_m3_oper !== 1'b0) begin failed++; $display("FAIL reset_oper got %0b want 0", bus.m2_m3_oper); end
      tests++;
      if (bus.m2_m3_multres !== 64'd0) begin failed++; $display("FAIL reset_multres got %h want 0", bus.m2_m3_multres); end
      tests++;
      if (bus.m2_busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %0b want 0", bus.m2_busy); end
      idle();
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_max_operands();
      drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b0);
      cyc();
      idle();
      tests++;
      if (bus.m2_m3_oper !== 1'b0) begin failed++; $display("FAIL max_latency_oper got %0b want 0", bus.m2_m3_oper); end
      cyc();
      tests++;
      if (bus.m2_m3_multres !== 64'hFFFF_FFFE_0000_0001) begin failed++; $display("FAIL max_multres got %h want fffffffe00000001", bus.m2_m3_multres); end
      tests++;
      if (bus.m2_m3_oper !== 1'b1 || bus.m2_m3_regdest !== 5'd9 || bus.m2_m3_ispositive !== 1'b1) begin
         failed++; $display("FAIL max_sideband got oper=%0b rd=%0d pos=%0b want 1/9/1", bus.m2_m3_oper, bus.m2_m3_regdest, bus.m2_m3_ispositive);
      end
      tests++;
      if (bus.m2_busy !== 1'b1) begin failed++; $display("FAIL max_busy got %0b want 1", bus.m2_busy); end
      cyc();
   endtask

   task automatic test_mixed_halves();
      drive(1'b1, 32'h0001_0002, 32'h0003_0004, 5'd11, 1'b0, 1'b0);
      cyc();
      idle();
      cyc();
      tests++;
      if (bus.m2_m3_multres !== 64'h0000_0003_000A_0008) begin failed++; $display("FAIL mixed_multres got %h want 00000003000a0008", bus.m2_m3_multres); end
      cyc();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'd3, 32'd5, 5'd1, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd2, 1'b0, 1'b0);
      cyc();
      idle();
      tests++;
      if (bus.m2_m3_multres !== 64'd15 || bus.m2_m3_regdest !== 5'd1 || bus.m2_m3_oper !== 1'b1) begin
         failed++; $display("FAIL b2b_first got res=%h rd=%0d oper=%0b want 15/1/1", bus.m2_m3_multres, bus.m2_m3_regdest, bus.m2_m3_oper);
      end
      cyc();
      tests++;
      if (bus.m2_m3_multres !== 64'h0000_0001_0000_0000 || bus.m2_m3_regdest !== 5'd2 || bus.m2_m3_ispositive !== 1'b0) begin
         failed++; $display("FAIL b2b_second got res=%h rd=%0d pos=%0b want 100000000/2/0", bus.m2_m3_multres, bus.m2_m3_regdest, bus.m2_m3_ispositive);
      end
      cyc();
      tests++;
      if (bus.m2_m3_oper !== 1'b0 || bus.m2_m3_multres !== 64'd0 || bus.m2_busy !== 1'b0) begin
         failed++; $display("FAIL b2b_drain got oper=%0b res=%h busy=%0b want 0/0/0", bus.m2_m3_oper, bus.m2_m3_multres, bus.m2_busy);
      end
   endtask

   task automatic test_stall();
      drive(1'b1, 32'd7, 32'd6, 5'd3, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 32'd2, 32'd3, 5'd5, 1'b1, 1'b0);
      cyc();
      bus.m2_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'd100 + 32'(i), 32'd50 + 32'(i), 5'(20 + i), 1'(i), 1'b0);
         cyc();
         tests++;
         if (bus.m2_m3_multres !== 64'd42 || bus.m2_m3_oper !== 1'b1 || bus.m2_m3_regdest !== 5'd3) begin
            failed++; $display("FAIL stall_hold[%0d] got res=%h oper=%0b rd=%0d want 42/1/3", i, bus.m2_m3_multres, bus.m2_m3_oper, bus.m2_m3_regdest);
         end
      end
      bus.m2_stall = 1'b0;
      idle();
      cyc();
      tests++;
      if (bus.m2_m3_multres !== 64'd6 || bus.m2_m3_regdest !== 5'd5 || bus.m2_m3_oper !== 1'b1) begin
         failed++; $display("FAIL stall_release got res=%h rd=%0d oper=%0b want 6/5/1", bus.m2_m3_multres, bus.m2_m3_regdest, bus.m2_m3_oper);
      end
      cyc();
   endtask

   task automatic test_flush();
      drive(1'b1, 32'd9, 32'd9, 5'd6, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 32'd4, 32'd4, 5'd7, 1'b1, 1'b0);
      cyc();
      tests++;
      if (bus.m2_m3_multres !== 64'd81 || bus.m2_busy !== 1'b1) begin
         failed++; $display("FAIL flush_pre got res=%h busy=%0b want 81/1", bus.m2_m3_multres, bus.m2_busy);
      end
      drive(1'b1, 32'd5, 32'd5, 5'd8, 1'b1, 1'b0);
      bus.m2_flush = 1'b1;
      bus.m2_stall = 1'b1;
      cyc();
      tests++;
      if (bus.m2_m3_oper !== 1'b0 || bus.m2_m3_multres !== 64'd0 || bus.m2_m3_regdest !== 5'd0 || bus.m2_busy !== 1'b0) begin
         failed++; $display("FAIL flush_kill got oper=%0b res=%h rd=%0d busy=%0b want 0/0/0/0", bus.m2_m3_oper, bus.m2_m3_multres, bus.m2_m3_regdest, bus.m2_busy);
      end
      bus.m2_flush = 1'b0;
      bus.m2_stall = 1'b0;
      idle();
      cyc();
      tests++;
      if (bus.m2_m3_oper !== 1'b0 || bus.m2_m3_multres !== 64'd0) begin
         failed++; $display("FAIL flush_dropped got oper=%0b res=%h want 0/0", bus.m2_m3_oper, bus.m2_m3_multres);
      end
   endtask

   task automatic test_zero_flag();
      drive(1'b1, 32'd7, 32'd0, 5'd4, 1'b0, 1'b1);
      cyc();
      drive(1'b1, 32'd7, 32'd5, 5'd12, 1'b1, 1'b1);
      cyc();
      idle();
      tests++;
      if (bus.m2_m3_multres !== 64'd0 || bus.m2_m3_oper !== 1'b1 || bus.m2_m3_iszero !== 1'b1 ||
          bus.m2_m3_ispositive !== 1'b0 || bus.m2_m3_regdest !== 5'd4) begin
         failed++; $display("FAIL zero_op got res=%h oper=%0b z=%0b pos=%0b rd=%0d want 0/1/1/0/4", bus.m2_m3_multres, bus.m2_m3_oper, bus.m2_m3_iszero, bus.m2_m3_ispositive, bus.m2_m3_regdest);
      end
      cyc();
      tests++;
      if (bus.m2_m3_multres !== 64'd0 || bus.m2_m3_regdest !== 5'd12 || bus.m2_m3_iszero !== 1'b1) begin
         failed++; $display("FAIL zero_forced got res=%h rd=%0d z=%0b want 0/12/1", bus.m2_m3_multres, bus.m2_m3_regdest, bus.m2_m3_iszero);
      end
      cyc();
   endtask

   task automatic test_async_reset();
      drive(1'b1, 32'd11, 32'd13, 5'd8, 1'b1, 1'b0);
      cyc();
      idle();
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if (bus.m2_busy !== 1'b0 || bus.m2_m3_oper !== 1'b0) begin
         failed++; $display("FAIL areset_immediate got busy=%0b oper=%0b want 0/0", bus.m2_busy, bus.m2_m3_oper);
      end
      cyc();
      tests++;
      if (bus.m2_m3_multres !== 64'd0) begin failed++; $display("FAIL areset_lost got res=%h want 0", bus.m2_m3_multres); end
      reset = 1'b1;
      drive(1'b1, 32'd12, 32'd12, 5'd10, 1'b1, 1'b0);
      cyc();
      idle();
      tests++;
      if (bus.m2_m3_oper !== 1'b0 || bus.m2_busy !== 1'b1) begin
         failed++; $display("FAIL areset_latency got oper=%0b busy=%0b want 0/1", bus.m2_m3_oper, bus.m2_busy);
      end
      cyc();
      tests++;
      if (bus.m2_m3_multres !== 64'd144 || bus.m2_m3_regdest !== 5'd10 || bus.m2_m3_oper !== 1'b1) begin
         failed++; $display("FAIL areset_resume got res=%h rd=%0d oper=%0b want 144/10/1", bus.m2_m3_multres, bus.m2_m3_regdest, bus.m2_m3_oper);
      end
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      test_reset();
      test_max_operands();
      test_mixed_halves();
      test_back_to_back();
      test_stall();
      test_flush();
      test_zero_flag();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
